// File: rtl/bus_pkg.sv
// bus_pkg: default bus widths, master request record and sequencer states for bus_arbiter.
package bus_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data_w;
        logic [DATA_W/8-1:0] mask_w;
        logic                write;
    } bus_req_t;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} arb_state_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-way grant picker; round-robin against last, or master 0 first when
// BUS_ARBITER_FIXED_PRIO_EN is defined.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       grant,
    output logic       valid
);
    assign valid = |req;
`ifdef BUS_ARBITER_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last;
    assign grant = ~req[0];
`else
    // a tie goes to the master that did not win last time
    assign grant = (&req) ? ~last : req[1];
`endif
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: serialises two masters onto one block-RAM port through IDLE/ACCESS/DONE;
// round-robin by default, fixed priority (master 0) when BUS_ARBITER_FIXED_PRIO_EN is defined.
module bus_arbiter #(
    parameter int ADDR_W = bus_pkg::ADDR_W,
    parameter int DATA_W = bus_pkg::DATA_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                m0_req,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_data_w,
    input  logic [DATA_W/8-1:0] m0_mask_w,
    input  logic                m0_write,
    output logic                m0_ack,
    output logic [DATA_W-1:0]   m0_data_r,
    input  logic                m1_req,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_data_w,
    input  logic [DATA_W/8-1:0] m1_mask_w,
    input  logic                m1_write,
    output logic                m1_ack,
    output logic [DATA_W-1:0]   m1_data_r,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_data_w,
    output logic [DATA_W/8-1:0] bus_mask_w,
    output logic                bus_write,
    input  logic [DATA_W-1:0]   bus_data_r
);
    import bus_pkg::*;

    arb_state_t          state, state_next;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_data_w;
    logic [DATA_W/8-1:0] req_mask_w;
    logic                req_write;
    logic                sel, last, grant, valid;

    rr_pick2 u_pick (
        .req   ({m1_req, m0_req}),
        .last  (last),
        .grant (grant),
        .valid (valid)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = (state == IDLE) ? (valid ? ACCESS : IDLE) : (state == ACCESS) ? DONE : IDLE;
        bus_write  = (state == ACCESS) && req_write;
        m0_ack     = (state == DONE) && !sel;
        m1_ack     = (state == DONE) && sel;
    end

    assign bus_addr   = req_addr;
    assign bus_data_w = req_data_w;
    assign bus_mask_w = req_mask_w;

`ifdef BUS_ARBITER_FIXED_PRIO_EN
    assign last = 1'b0;
`else
    always_ff @(posedge clock) begin
        if (reset)
            last <= 1'b1;
        else if (state == IDLE && valid)
            last <= grant;
    end
`endif

    // read data is captured on the edge into DONE so it is already valid during the ack
    always_ff @(posedge clock) begin
        if (reset) begin
            sel        <= 1'b0;
            req_addr   <= '0;
            req_data_w <= '0;
            req_mask_w <= '0;
            req_write  <= 1'b0;
            m0_data_r  <= '0;
            m1_data_r  <= '0;
        end else begin
            if (state == IDLE && valid) begin
                sel        <= grant;
                req_addr   <= grant ? m1_addr : m0_addr;
                req_data_w <= grant ? m1_data_w : m0_data_w;
                req_mask_w <= grant ? m1_mask_w : m0_mask_w;
                req_write  <= grant ? m1_write : m0_write;
            end
            if (state == ACCESS && !req_write && !sel)
                m0_data_r <= bus_data_r;
            if (state == ACCESS && !req_write && sel)
                m1_data_r <= bus_data_r;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table vectors, directed multi-cycle sequences and a randomized run
// checked against a transaction-level model with a shadow memory.
module tb_bus_arbiter;
    import bus_pkg::*;
    localparam int MW = DATA_W / 8;
`ifdef BUS_ARBITER_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clock = 1'b0, reset = 1'b1;
    logic m0_req = 1'b0, m1_req = 1'b0, m0_write = 1'b0, m1_write = 1'b0;
    logic [ADDR_W-1:0] m0_addr = '0, m1_addr = '0;
    logic [DATA_W-1:0] m0_data_w = '0, m1_data_w = '0;
    logic [MW-1:0] m0_mask_w = '0, m1_mask_w = '0;
    logic m0_ack, m1_ack, bus_write;
    logic [DATA_W-1:0] m0_data_r, m1_data_r, bus_data_w;
    logic [DATA_W-1:0] bus_data_r = '0;
    logic [ADDR_W-1:0] bus_addr;
    logic [MW-1:0] bus_mask_w;
    logic poke_en = 1'b0;
    logic [3:0] poke_addr = '0;
    logic [DATA_W-1:0] poke_data = '0;
    logic [DATA_W-1:0] mem [16];
    int checks = 0, errors = 0;

    bus_arbiter dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_data_w(m0_data_w), .m0_mask_w(m0_mask_w),
        .m0_write(m0_write), .m0_ack(m0_ack), .m0_data_r(m0_data_r),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_data_w(m1_data_w), .m1_mask_w(m1_mask_w),
        .m1_write(m1_write), .m1_ack(m1_ack), .m1_data_r(m1_data_r),
        .bus_addr(bus_addr), .bus_data_w(bus_data_w), .bus_mask_w(bus_mask_w),
        .bus_write(bus_write), .bus_data_r(bus_data_r)
    );

    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old,
                                                input logic [DATA_W-1:0] d, input logic [MW-1:0] k);
        logic [DATA_W-1:0] r;
        r = old;
        for (int b = 0; b < MW; b++)
            if (k[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // block RAM on the falling edge; poke lets the bench preload words
    always @(negedge clock) begin
        if (poke_en)
            mem[poke_addr] <= poke_data;
        else if (bus_write)
            mem[bus_addr[3:0]] <= merge(mem[bus_addr[3:0]], bus_data_w, bus_mask_w);
        bus_data_r <= mem[bus_addr[3:0]];
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [3:0] a, input logic [DATA_W-1:0] d);
        poke_addr = a;
        poke_data = d;
        poke_en = 1'b1;
        tick;
        poke_en = 1'b0;
    endtask

    task automatic drive(input int m, input logic rq, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [MW-1:0] k);
        if (m == 0) begin
            m0_req = rq; m0_write = wr; m0_addr = a; m0_data_w = d; m0_mask_w = k;
        end else begin
            m1_req = rq; m1_write = wr; m1_addr = a; m1_data_w = d; m1_mask_w = k;
        end
    endtask

    function automatic logic ack_of(input int m);
        return (m == 0) ? m0_ack : m1_ack;
    endfunction

    function automatic logic [DATA_W-1:0] dr_of(input int m);
        return (m == 0) ? m0_data_r : m1_data_r;
    endfunction

    task automatic do_reset;
        reset = 1'b1;
        tick;
        reset = 1'b0;
    endtask

    typedef struct {
        int m;
        logic wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MW-1:0] mask;
        logic [DATA_W-1:0] pre;
        logic [DATA_W-1:0] exp_dr;
        logic [DATA_W-1:0] exp_mem;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int ack_at, wc, oth;
        logic [DATA_W-1:0] dr;
        ack_at = 0; wc = 0; oth = 0; dr = '0;
        poke(v.addr[3:0], v.pre);
        drive(v.m, 1'b1, v.wr, v.addr, v.wdata, v.mask);
        for (int n = 1; n <= 6; n++) begin
            tick;
            if (n == 1) begin
                chk("vec_bus_addr", bus_addr, v.addr);
                if (v.wr) chk("vec_bus_data_w", {bus_data_w, bus_mask_w}, {v.wdata, v.mask});
            end
            wc += int'(bus_write);
            oth += int'(ack_of(1 - v.m));
            if (ack_of(v.m)) begin
                if (ack_at == 0) begin
                    ack_at = n;
                    dr = dr_of(v.m);
                    drive(v.m, 1'b0, 1'b0, '0, '0, '0);
                end else ack_at = 99;
            end
        end
        chk("vec_ack_cycle", 64'(ack_at), 2);
        chk("vec_bus_write_cycles", 64'(wc), {63'd0, v.wr});
        chk("vec_other_ack", 64'(oth), 0);
        chk("vec_data_r", dr, v.exp_dr);
        chk("vec_mem", mem[v.addr[3:0]], v.exp_mem);
    endtask

    initial begin
        vec_t tbl[6];
        int am[$], ac[$];
        int ack0, ack1;
        logic [DATA_W-1:0] sh [16];
        logic [DATA_W-1:0] exp_dr[2], pend_dr[2];
        logic cur_v[2], cur_wr[2];
        logic [3:0] cur_a[2];
        logic [DATA_W-1:0] cur_d[2];
        logic [MW-1:0] cur_k[2];
        int e, free_edge, bw_e, last_m, w;
        int ack_e[2];
        logic r0, r1;

        tbl[0] = '{0, 1'b0, 5, 0, 4'b0000, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1] = '{1, 1'b1, 3, 32'h11223344, 4'b0011, 32'hAABBCCDD, 32'h0, 32'hAABB3344};
        tbl[2] = '{0, 1'b1, 7, 32'hCAFEBABE, 4'b1100, 32'h01234567, 32'hDEADBEEF, 32'hCAFE4567};
        tbl[3] = '{1, 1'b1, 2, 32'hFFFFFFFF, 4'b0000, 32'h12345678, 32'h0, 32'h12345678};
        tbl[4] = '{0, 1'b1, 0, 32'h87654321, 4'b1111, 32'h0, 32'hDEADBEEF, 32'h87654321};
        tbl[5] = '{1, 1'b0, 3, 0, 4'b0000, 32'h0BADF00D, 32'h0BADF00D, 32'h0BADF00D};

        tick;
        tick;
        chk("rst_m0_ack", m0_ack, 0);
        chk("rst_m1_ack", m1_ack, 0);
        chk("rst_bus_write", bus_write, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_data_w", bus_data_w, 0);
        chk("rst_bus_mask_w", bus_mask_w, 0);
        chk("rst_m0_data_r", m0_data_r, 0);
        chk("rst_m1_data_r", m1_data_r, 0);
        reset = 1'b0;

        foreach (tbl[i]) run_vec(tbl[i]);

        // both masters requesting continuously from a fresh reset
        poke(1, 32'hA1A1A1A1);
        poke(4, 32'hB4B4B4B4);
        do_reset;
        drive(0, 1'b1, 1'b0, 1, '0, '0);
        drive(1, 1'b1, 1'b0, 4, '0, '0);
        for (int n = 1; n <= 12; n++) begin
            tick;
            if (m0_ack) begin
                am.push_back(0); ac.push_back(n);
                chk("cont_m0_data", m0_data_r, 32'hA1A1A1A1);
            end
            if (m1_ack) begin
                am.push_back(1); ac.push_back(n);
                chk("cont_m1_data", m1_data_r, 32'hB4B4B4B4);
            end
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        chk("cont_ack_count", 64'(am.size()), 4);
        for (int i = 0; i < 4 && i < am.size(); i++) begin
            chk("cont_grant_order", 64'(am[i]), FIXED ? 64'd0 : 64'(i % 2));
            chk("cont_ack_cycle", 64'(ac[i]), 64'(2 + 3 * i));
        end
        tick;

        // m1 arrives while m0 is in ACCESS
        poke(9, 32'h13579BDF);
        poke(10, 32'h2468ACE0);
        drive(0, 1'b1, 1'b0, 9, '0, '0);
        tick;
        drive(1, 1'b1, 1'b0, 10, '0, '0);
        ack0 = 0; ack1 = 0;
        for (int n = 2; n <= 8; n++) begin
            tick;
            if (m0_ack && ack0 == 0) begin
                ack0 = n;
                chk("late_m0_data", m0_data_r, 32'h13579BDF);
                drive(0, 1'b0, 1'b0, '0, '0, '0);
            end
            if (m1_ack && ack1 == 0) begin
                ack1 = n;
                chk("late_m1_data", m1_data_r, 32'h2468ACE0);
                drive(1, 1'b0, 1'b0, '0, '0, '0);
            end
        end
        chk("late_m0_ack_cycle", 64'(ack0), 2);
        chk("late_m1_ack_cycle", 64'(ack1), 5);

        // reset while m0's read is in ACCESS, then the re-issued read
        poke(12, 32'h55AA55AA);
        drive(0, 1'b1, 1'b0, 12, '0, '0);
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        chk("rsta_m0_ack", m0_ack, 0);
        chk("rsta_m0_data_r", m0_data_r, 0);
        chk("rsta_bus_addr", bus_addr, 0);
        ack0 = 0;
        for (int n = 1; n <= 4; n++) begin
            tick;
            if (m0_ack && ack0 == 0) begin
                ack0 = n;
                chk("rsta_reissue_data", m0_data_r, 32'h55AA55AA);
                drive(0, 1'b0, 1'b0, '0, '0, '0);
            end
        end
        chk("rsta_reissue_ack_cycle", 64'(ack0), 2);

        // reset while m1's read is in DONE
        poke(13, 32'h77778888);
        drive(1, 1'b1, 1'b0, 13, '0, '0);
        tick;
        tick;
        chk("rstd_m1_ack", m1_ack, 1);
        chk("rstd_m1_data_r", m1_data_r, 32'h77778888);
        reset = 1'b1;
        #1;
        chk("rstd_ack_held", m1_ack, 1);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        tick;
        reset = 1'b0;
        chk("rstd_after_ack", m1_ack, 0);
        chk("rstd_after_data_r", m1_data_r, 0);

        // randomized traffic against a transaction-level model
        for (int i = 0; i < 16; i++) begin
            sh[i] = $urandom;
            poke(4'(i), sh[i]);
        end
        do_reset;
        e = 0; free_edge = 0; bw_e = -1; last_m = 1;
        for (int m = 0; m < 2; m++) begin
            ack_e[m] = -1; exp_dr[m] = '0; pend_dr[m] = '0; cur_v[m] = 1'b0;
            cur_wr[m] = 1'b0; cur_a[m] = '0; cur_d[m] = '0; cur_k[m] = '0;
        end
        for (int c = 0; c < 600; c++) begin
            r0 = m0_req;
            r1 = m1_req;
            tick;
            e++;
            if (e >= free_edge && (r0 || r1)) begin
                w = (r0 && r1) ? (FIXED ? 0 : 1 - last_m) : (r1 ? 1 : 0);
                last_m = w;
                free_edge = e + 3;
                ack_e[w] = e + 1;
                if (cur_wr[w]) begin
                    sh[cur_a[w]] = merge(sh[cur_a[w]], cur_d[w], cur_k[w]);
                    bw_e = e;
                end else pend_dr[w] = sh[cur_a[w]];
            end
            for (int m = 0; m < 2; m++)
                if (ack_e[m] == e && !cur_wr[m]) exp_dr[m] = pend_dr[m];
            chk("rnd_m0_ack", m0_ack, 64'(ack_e[0] == e));
            chk("rnd_m1_ack", m1_ack, 64'(ack_e[1] == e));
            chk("rnd_bus_write", bus_write, 64'(bw_e == e));
            chk("rnd_m0_data_r", m0_data_r, exp_dr[0]);
            chk("rnd_m1_data_r", m1_data_r, exp_dr[1]);
            for (int m = 0; m < 2; m++) begin
                if (ack_e[m] == e) cur_v[m] = 1'b0;
                if (!cur_v[m] && $urandom_range(0, 2) == 0) begin
                    cur_v[m] = 1'b1;
                    cur_wr[m] = 1'($urandom_range(0, 1));
                    cur_a[m] = 4'($urandom_range(0, 15));
                    cur_d[m] = $urandom;
                    cur_k[m] = MW'($urandom);
                end
                drive(m, cur_v[m], cur_wr[m], ADDR_W'(cur_a[m]), cur_d[m], cur_k[m]);
            end
        end
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        repeat (4) tick;
        for (int i = 0; i < 16; i++) chk("rnd_mem", mem[i], sh[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule
